// File: rtl/usb_rx_decoder_if.sv
// usb_rx_decoder_if: sampled DP/DM line levels in, decoded data-bit stream and packet strobes out.
interface usb_rx_decoder_if;
    logic       dp_in;
    logic       dm_in;
    logic       bit_out;
    logic       bit_valid;
    logic       rx_start;
    logic       rx_active;
    logic       rx_done;
    logic       rx_error;
    logic [7:0] rx_bit_count;
    modport master (
        output dp_in, dm_in,
        input  bit_out, bit_valid, rx_start, rx_active, rx_done, rx_error, rx_bit_count
    );
    modport slave (
        input  dp_in, dm_in,
        output bit_out, bit_valid, rx_start, rx_active, rx_done, rx_error, rx_bit_count
    );
endinterface

// File: rtl/usb_rx_decoder.sv
// usb_rx_decoder: per-bit DP/DM sampler that finds SYNC, NRZI-decodes, strips stuffed bits
// and checks EOP, delivering a data-bit stream with start/done/error strobes.
module usb_rx_decoder #(
    parameter int MAX_BITS = 96
) (
    input logic             clk,
    input logic             rst_L,
    usb_rx_decoder_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP1, EOP2, ERR_WAIT} state_t;
    localparam logic [7:0] MAX_CNT = 8'(MAX_BITS);

    state_t     r_state, w_state;
    logic       r_prev, w_prev;
    logic [2:0] r_sync_cnt, w_sync_cnt;
    logic [2:0] r_ones_cnt, w_ones_cnt;
    logic [7:0] r_bit_count, w_bit_count;
    logic       r_bit, w_bit;
    logic       r_valid, w_valid;
    logic       r_start, w_start;
    logic       r_active, w_active;
    logic       r_done, w_done;
    logic       r_error, w_error;
    logic       w_jk, w_j, w_k, w_se0, w_se1, w_dec;

    assign w_jk  = bus.dp_in ^ bus.dm_in;
    assign w_j   = w_jk & bus.dp_in;
    assign w_k   = w_jk & ~bus.dp_in;
    assign w_se0 = ~bus.dp_in & ~bus.dm_in;
    assign w_se1 = bus.dp_in & bus.dm_in;
    // prev_line is kept as its DP level; a repeated level decodes as 1
    assign w_dec = bus.dp_in == r_prev;

    always_comb begin
        w_state     = r_state;
        w_prev      = w_jk ? bus.dp_in : r_prev;
        w_sync_cnt  = r_sync_cnt;
        w_ones_cnt  = r_ones_cnt;
        w_bit_count = r_bit_count;
        w_bit       = 1'b0;
        w_valid     = 1'b0;
        w_start     = 1'b0;
        w_done      = 1'b0;
        w_error     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_se1) begin
                    w_state = ERR_WAIT;
                end else if (w_k && !w_dec) begin
                    w_state     = SYNC;
                    w_sync_cnt  = 3'd1;
                    w_bit_count = '0;
                end
            end
            SYNC: begin
                if (!w_jk) begin
                    w_state = ERR_WAIT;
                    w_error = 1'b1;
                end else if (r_sync_cnt == 3'd7) begin
                    w_state    = w_dec ? DATA : IDLE;
                    w_ones_cnt = 3'd1;
                end else if (w_dec) begin
                    w_state = IDLE;
                end else begin
                    w_sync_cnt = r_sync_cnt + 3'd1;
                end
            end
            DATA: begin
                if (w_se0) begin
                    w_state = EOP1;
                end else if (w_se1 || (r_ones_cnt == 3'd6 ? w_dec : r_bit_count == MAX_CNT)) begin
                    w_state = ERR_WAIT;
                    w_error = 1'b1;
                end else if (r_ones_cnt == 3'd6) begin
                    w_ones_cnt = '0;
                end else begin
                    w_valid     = 1'b1;
                    w_bit       = w_dec;
                    w_start     = r_bit_count == '0;
                    w_bit_count = r_bit_count + 8'd1;
                    w_ones_cnt  = w_dec ? r_ones_cnt + 3'd1 : 3'd0;
                end
            end
            EOP1: begin
                w_state = w_se0 ? EOP2 : ERR_WAIT;
                w_error = !w_se0;
            end
            EOP2: begin
                w_state = w_j ? IDLE : ERR_WAIT;
                w_done  = w_j;
                w_error = !w_j;
            end
            ERR_WAIT: w_state = w_j ? IDLE : ERR_WAIT;
            default:  w_state = IDLE;
        endcase
        // active through the done/error cycle, dropping one cycle later
        w_active = w_state == SYNC || w_state == DATA || w_state == EOP1 || w_state == EOP2 || w_done || w_error;
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_state     <= IDLE;
            r_prev      <= 1'b1;
            r_sync_cnt  <= '0;
            r_ones_cnt  <= '0;
            r_bit_count <= '0;
            r_bit       <= 1'b0;
            r_valid     <= 1'b0;
            r_start     <= 1'b0;
            r_active    <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_prev      <= w_prev;
            r_sync_cnt  <= w_sync_cnt;
            r_ones_cnt  <= w_ones_cnt;
            r_bit_count <= w_bit_count;
            r_bit       <= w_bit;
            r_valid     <= w_valid;
            r_start     <= w_start;
            r_active    <= w_active;
            r_done      <= w_done;
            r_error     <= w_error;
        end
    end

    assign bus.bit_out      = r_bit;
    assign bus.bit_valid    = r_valid;
    assign bus.rx_start     = r_start;
    assign bus.rx_active    = r_active;
    assign bus.rx_done      = r_done;
    assign bus.rx_error     = r_error;
    assign bus.rx_bit_count = r_bit_count;
endmodule

// File: tb/tb_usb_rx_decoder.sv
// tb_usb_rx_decoder: builds USB line streams the way a transmitter would (stuffing, NRZI, EOP),
// records the expected per-sample response alongside, and compares the decoder against it.
module tb_usb_rx_decoder;
    localparam int MAX_BITS = 96;
    localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00, SE1 = 2'b11;
    // expected-response flags: {valid, bit, start, done, error, active}
    localparam logic [5:0] V = 6'b100000, B = 6'b010000, S = 6'b001000;
    localparam logic [5:0] D = 6'b000100, E = 6'b000010, A = 6'b000001;

    logic clk = 1'b0;
    logic rst_L = 1'b0;
    usb_rx_decoder_if bus();
    usb_rx_decoder #(.MAX_BITS(MAX_BITS)) dut (.clk(clk), .rst_L(rst_L), .bus(bus));
    always #5 clk = ~clk;

    logic [1:0] line_q[$];
    logic [5:0] exp_q[$];
    logic       bits_q[$];
    logic       lvl;
    int         ones, n_data, exp_count, pkt;
    logic       erred;
    int         n_checks = 0, n_errors = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [5:0] outs();
        return {bus.bit_valid, bus.bit_out & bus.bit_valid, bus.rx_start, bus.rx_done, bus.rx_error, bus.rx_active};
    endfunction

    task automatic sym(logic [1:0] s, logic [5:0] e);
        line_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic nrzi(logic b, logic [5:0] e);
        if (!b) lvl = ~lvl;
        sym(lvl ? J : K, e);
    endtask

    task automatic idle(int n);
        repeat (n) sym(J, 6'd0);
        lvl = 1'b1;
    endtask

    task automatic sync_hdr();
        exp_count = 0;
        n_data    = 0;
        erred     = 1'b0;
        repeat (7) nrzi(1'b0, A);
        nrzi(1'b1, A);
        ones = 1;
    endtask

    task automatic data_raw(logic b);
        if (n_data == MAX_BITS) begin
            nrzi(b, E | A);
            erred = 1'b1;
            return;
        end
        nrzi(b, V | (b ? B : 6'd0) | (n_data == 0 ? S : 6'd0) | A);
        n_data++;
        exp_count = n_data;
        ones = b ? ones + 1 : 0;
    endtask

    task automatic data(logic b);
        data_raw(b);
        if (!erred && ones == 6) begin
            nrzi(1'b0, A);
            ones = 0;
        end
    endtask

    task automatic eop();
        sym(SE0, A);
        sym(SE0, A);
        sym(J, D | A);
        lvl = 1'b1;
    endtask

    task automatic err_tail();
        repeat ($urandom_range(0, 2)) begin
            int r = $urandom_range(0, 2);
            sym(r == 0 ? K : r == 1 ? SE0 : SE1, 6'd0);
        end
        idle(2);
    endtask

    function automatic logic [127:0] rnd_bits();
        logic [127:0] v;
        logic all_ones = $urandom_range(0, 3) == 0;
        for (int i = 0; i < 128; i++) v[i] = all_ones | 1'($urandom_range(0, 1));
        return v;
    endfunction

    task automatic good_pkt(logic [127:0] v, int n);
        idle($urandom_range(1, 4));
        sync_hdr();
        for (int i = 0; i < n; i++) data(v[i]);
        eop();
        idle(1);
    endtask

    task automatic stuff_err(int pre);
        logic [127:0] v = rnd_bits();
        idle($urandom_range(1, 4));
        sync_hdr();
        for (int i = 0; i < pre; i++) data(v[i]);
        while (ones < 6) data_raw(1'b1);
        nrzi(1'b1, E | A);
        err_tail();
    endtask

    // p is the symbol (2..8) that breaks the SYNC pattern; se0 makes it a line error instead of noise
    task automatic bad_sync(int p, logic se0);
        idle($urandom_range(1, 4));
        exp_count = 0;
        for (int s = 1; s < p; s++) nrzi(1'b0, A);
        if (se0) begin
            sym(SE0, E | A);
            err_tail();
        end else begin
            nrzi(p == 8 ? 1'b0 : 1'b1, 6'd0);
            idle(2);
        end
    endtask

    task automatic bad_eop(int n, int variant);
        logic [127:0] v = rnd_bits();
        idle($urandom_range(1, 4));
        sync_hdr();
        for (int i = 0; i < n; i++) data(v[i]);
        case (variant)
            0: begin sym(SE0, A); sym(J, E | A); end
            1: begin sym(SE0, A); sym(SE0, A); sym(SE0, E | A); end
            2: begin sym(SE0, A); sym(SE0, A); sym(K, E | A); end
            default: sym(SE1, E | A);
        endcase
        err_tail();
    endtask

    task automatic overlength();
        logic [127:0] v = rnd_bits();
        idle($urandom_range(1, 4));
        sync_hdr();
        for (int i = 0; i <= MAX_BITS; i++) data(v[i]);
        err_tail();
    endtask

    task automatic run_q(int limit);
        bits_q.delete();
        for (int i = 0; i < limit && i < line_q.size(); i++) begin
            {bus.dp_in, bus.dm_in} = line_q[i];
            @(posedge clk);
            #1;
            check($sformatf("pkt%0d.s%0d", pkt, i), 32'(outs()), 32'(exp_q[i]));
            if (bus.bit_valid) bits_q.push_back(bus.bit_out);
        end
        line_q.delete();
        exp_q.delete();
    endtask

    task automatic run_pkt();
        run_q(1 << 30);
        check($sformatf("pkt%0d.count", pkt), 32'(bus.rx_bit_count), 32'(exp_count));
        pkt++;
    endtask

    function automatic logic [7:0] byte_at(int base);
        logic [7:0] r = '0;
        for (int i = 0; i < 8; i++) if (base + i < bits_q.size()) r[i] = bits_q[base + i];
        return r;
    endfunction

    task automatic reset_mid();
        good_pkt(rnd_bits(), 40);
        run_q(15 + $urandom_range(0, 20));
        rst_L = 1'b0;
        #1;
        check($sformatf("pkt%0d.rst_outs", pkt), 32'(outs()), 32'd0);
        check($sformatf("pkt%0d.rst_count", pkt), 32'(bus.rx_bit_count), 32'd0);
        @(posedge clk);
        #1;
        check($sformatf("pkt%0d.rst_hold", pkt), 32'(outs()), 32'd0);
        rst_L = 1'b1;
        exp_count = 0;
        pkt++;
    endtask

    initial begin
        bus.dp_in = 1'b1;
        bus.dm_in = 1'b0;
        pkt = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", 32'(outs()), 32'd0);
        check("reset_count", 32'(bus.rx_bit_count), 32'd0);
        rst_L = 1'b1;

        good_pkt(128'hD2, 8);
        run_pkt();
        check("ack_pid", 32'(byte_at(0)), 32'hD2);
        good_pkt(128'hFFC3, 16);
        run_pkt();
        check("data0_pid", 32'(byte_at(0)), 32'hC3);
        check("data0_byte", 32'(byte_at(8)), 32'hFF);
        good_pkt(128'h0, 0);
        run_pkt();
        stuff_err(0);
        run_pkt();
        bad_sync(5, 1'b0);
        good_pkt(128'hD2, 8);
        run_pkt();
        check("ack_after_noise", 32'(byte_at(0)), 32'hD2);
        bad_eop(8, 0);
        run_pkt();
        bad_eop(8, 1);
        run_pkt();
        overlength();
        run_pkt();
        reset_mid();
        good_pkt(128'hD2, 8);
        run_pkt();

        repeat (40) begin
            case ($urandom_range(0, 5))
                0: good_pkt(rnd_bits(), $urandom_range(0, MAX_BITS));
                1: stuff_err($urandom_range(0, 20));
                2: bad_sync($urandom_range(2, 8), $urandom_range(0, 3) == 0);
                3: bad_eop($urandom_range(1, 16), $urandom_range(0, 3));
                4: overlength();
                default: reset_mid();
            endcase
            if (line_q.size() > 0) run_pkt();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end
endmodule
